unified_memory_arbiter: RTL and testbench

Shares one single-port memory between the phoeniX instruction and data memory interfaces. It sits between the core and a variable-latency memory (SRAM or bus bridge), serializes requests with data-priority arbitration and an anti-starvation guard, and returns completion pulses so the core can stall. Data writes to the console address bypass memory and are emitted on a byte console port.

---
 rtl/unified_memory_arbiter_pkg.sv | 39 +++
 rtl/unified_memory_arbiter_priority_guard.sv | 42 ++++
 rtl/unified_memory_arbiter.sv | 175 +++++++++++++++++
 tb/tb_unified_memory_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_memory_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_memory_arbiter_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned WORD_ADDR_W = 30;
   localparam int unsigned MASK_W      = 4;
   localparam int unsigned CONSOLE_W   = 8;

   // Data access direction, matching the core's READ/WRITE encoding
   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   localparam logic [ADDR_W-1:0] DEFAULT_CONSOLE_ADDRESS = 32'h1000_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_BUSY_I = 2'b01,
      ST_BUSY_D = 2'b10,
      ST_DONE   = 2'b11
   } state_e;

   typedef struct packed {
      logic                   write;
      logic [WORD_ADDR_W-1:0] addr;
      logic [MASK_W-1:0]      be;
      logic [DATA_W-1:0]      wdata;
   } mem_cmd_t;

   // Core frame mask is byte-reversed relative to the memory byte enables
   function automatic logic [MASK_W-1:0] mask_to_be(input logic [MASK_W-1:0] mask);
      logic [MASK_W-1:0] be;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         be[i] = mask[MASK_W-1-i];
      end
      return be;
   endfunction

endpackage

// File: rtl/unified_memory_arbiter_priority_guard.sv
// Data-priority winner select with a saturating streak counter that
// guarantees an instruction request is served after MAX_DATA_STREAK data grants.
module arbiter_priority_guard #(
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic idle,
   input  logic instr_enable,
   input  logic data_enable,
   output logic grant_instr_c,
   output logic grant_data_c
);

   localparam int unsigned STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);

   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                at_limit;

   always_comb begin
      at_limit      = (streak_q == STREAK_W'(MAX_DATA_STREAK));
      grant_data_c  = idle && data_enable && !(instr_enable && at_limit);
      grant_instr_c = idle && instr_enable && !grant_data_c;
      streak_d      = streak_q;
      if (idle) begin
         if (grant_instr_c || !instr_enable) begin
            streak_d = '0;
         end else if (grant_data_c && !at_limit) begin
            streak_d = streak_q + STREAK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Serializes phoeniX instruction and data requests onto one single-port
// memory; console-address data accesses bypass memory entirely.
module unified_memory_arbiter
   import unified_memory_arbiter_pkg::*;
#(
   parameter int unsigned       MAX_DATA_STREAK = 4,
   parameter logic [ADDR_W-1:0] CONSOLE_ADDRESS = DEFAULT_CONSOLE_ADDRESS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   instr_enable,
   input  logic [ADDR_W-1:0]      instr_address,
   output logic [DATA_W-1:0]      instr_data,
   output logic                   instr_ready,
   input  logic                   data_enable,
   input  logic                   data_state,
   input  logic [ADDR_W-1:0]      data_address,
   input  logic [MASK_W-1:0]      data_frame_mask,
   input  logic [DATA_W-1:0]      data_wdata,
   output logic [DATA_W-1:0]      data_rdata,
   output logic                   data_ready,
   output logic                   mem_req,
   output logic                   mem_write,
   output logic [WORD_ADDR_W-1:0] mem_address,
   output logic [MASK_W-1:0]      mem_byte_enable,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_ack,
   output logic                   console_valid,
   output logic [CONSOLE_W-1:0]   console_data
);

   state_e                 state_q, state_d;
   mem_cmd_t               cmd_q, cmd_d;
   logic                   grant_data_q, grant_data_d;
   logic                   console_q, console_d;
   logic                   console_wr_q, console_wr_d;
   logic                   mem_req_q, mem_req_d;
   logic                   instr_ready_q, instr_ready_d;
   logic                   data_ready_q, data_ready_d;
   logic                   console_valid_q, console_valid_d;
   logic [DATA_W-1:0]      instr_data_q, instr_data_d;
   logic [DATA_W-1:0]      data_rdata_q, data_rdata_d;
   logic [CONSOLE_W-1:0]   console_data_q, console_data_d;
   logic                   grant_instr_c, grant_data_c;
   logic                   is_console_c;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^{instr_address[1:0], data_address[1:0]};

   arbiter_priority_guard #(
      .MAX_DATA_STREAK(MAX_DATA_STREAK)
   ) u_guard (
      .clk          (clk),
      .rst_n        (reset),
      .idle         (state_q == ST_IDLE),
      .instr_enable (instr_enable),
      .data_enable  (data_enable),
      .grant_instr_c(grant_instr_c),
      .grant_data_c (grant_data_c)
   );

   // Next-state and registered-output computation
   always_comb begin
      state_d         = state_q;
      cmd_d           = cmd_q;
      grant_data_d    = grant_data_q;
      console_d       = console_q;
      console_wr_d    = console_wr_q;
      instr_data_d    = instr_data_q;
      data_rdata_d    = data_rdata_q;
      console_data_d  = console_data_q;
      mem_req_d       = 1'b0;
      instr_ready_d   = 1'b0;
      data_ready_d    = 1'b0;
      console_valid_d = 1'b0;
      is_console_c    = (data_address[ADDR_W-1:2] == CONSOLE_ADDRESS[ADDR_W-1:2]);

      case (state_q)
         ST_IDLE: begin
            if (grant_data_c) begin
               grant_data_d = 1'b1;
               console_d    = is_console_c;
               console_wr_d = is_console_c && (data_state == WRITE);
               if (is_console_c) begin
                  state_d = ST_DONE;
                  if (data_state == WRITE) begin
                     console_data_d = data_wdata[CONSOLE_W-1:0];
                  end else begin
                     data_rdata_d = '0;
                  end
               end else begin
                  state_d     = ST_BUSY_D;
                  cmd_d.write = (data_state == WRITE);
                  cmd_d.addr  = data_address[ADDR_W-1:2];
                  cmd_d.be    = mask_to_be(data_frame_mask);
                  cmd_d.wdata = data_wdata;
               end
            end else if (grant_instr_c) begin
               state_d      = ST_BUSY_I;
               grant_data_d = 1'b0;
               console_d    = 1'b0;
               console_wr_d = 1'b0;
               cmd_d.write  = 1'b0;
               cmd_d.addr   = instr_address[ADDR_W-1:2];
               cmd_d.be     = '1;
               cmd_d.wdata  = '0;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            // An ack is only honoured once the request is visible to memory
            if (mem_ack && mem_req_q) begin
               state_d = ST_DONE;
               if (state_q == ST_BUSY_I) begin
                  instr_data_d = mem_rdata;
               end else begin
                  data_rdata_d = mem_rdata;
               end
            end else begin
               mem_req_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d         = ST_IDLE;
            instr_ready_d   = !grant_data_q;
            data_ready_d    = grant_data_q;
            console_valid_d = console_q && console_wr_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         cmd_q           <= '0;
         grant_data_q    <= 1'b0;
         console_q       <= 1'b0;
         console_wr_q    <= 1'b0;
         mem_req_q       <= 1'b0;
         instr_ready_q   <= 1'b0;
         data_ready_q    <= 1'b0;
         console_valid_q <= 1'b0;
         instr_data_q    <= '0;
         data_rdata_q    <= '0;
         console_data_q  <= '0;
      end else begin
         state_q         <= state_d;
         cmd_q           <= cmd_d;
         grant_data_q    <= grant_data_d;
         console_q       <= console_d;
         console_wr_q    <= console_wr_d;
         mem_req_q       <= mem_req_d;
         instr_ready_q   <= instr_ready_d;
         data_ready_q    <= data_ready_d;
         console_valid_q <= console_valid_d;
         instr_data_q    <= instr_data_d;
         data_rdata_q    <= data_rdata_d;
         console_data_q  <= console_data_d;
      end
   end

   assign mem_req         = mem_req_q;
   assign mem_write       = cmd_q.write;
   assign mem_address     = cmd_q.addr;
   assign mem_byte_enable = cmd_q.be;
   assign mem_wdata       = cmd_q.wdata;
   assign instr_ready     = instr_ready_q;
   assign instr_data      = instr_data_q;
   assign data_ready      = data_ready_q;
   assign data_rdata      = data_rdata_q;
   assign console_valid   = console_valid_q;
   assign console_data    = console_data_q;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Scoreboard bench for unified_memory_arbiter with a variable-latency memory responder.
module tb_unified_memory_arbiter;
   import unified_memory_arbiter_pkg::*;

   logic        clk, reset;
   logic        instr_enable, data_enable, data_state, mem_ack;
   logic [31:0] instr_address, data_address, data_wdata, mem_rdata;
   logic [3:0]  data_frame_mask;
   logic [31:0] instr_data, data_rdata, mem_wdata;
   logic        instr_ready, data_ready, mem_req, mem_write, console_valid;
   logic [29:0] mem_address;
   logic [3:0]  mem_byte_enable;
   logic [7:0]  console_data;

   unified_memory_arbiter dut (
      .clk(clk), .reset(reset),
      .instr_enable(instr_enable), .instr_address(instr_address),
      .instr_data(instr_data), .instr_ready(instr_ready),
      .data_enable(data_enable), .data_state(data_state), .data_address(data_address),
      .data_frame_mask(data_frame_mask), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_ready(data_ready),
      .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .console_valid(console_valid), .console_data(console_data)
   );

   wire [142:0] all_out = {mem_req, mem_write, mem_address, mem_byte_enable, mem_wdata,
                           instr_ready, data_ready, instr_data, data_rdata,
                           console_valid, console_data};

   typedef struct packed {
      logic        is_data;
      logic        console;
      logic        chk;
      logic [31:0] rdata;
      logic [7:0]  cdata;
   } exp_t;

   exp_t        exp_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          ack_delay = 0;
   bit          force_ack = 0;
   logic [31:0] mem_resp = 32'h0;

   function automatic exp_t make_exp(input logic is_d, input logic con, input logic chk,
                                     input logic [31:0] rd, input logic [7:0] cd);
      exp_t e;
      e.is_data = is_d; e.console = con; e.chk = chk; e.rdata = rd; e.cdata = cd;
      return e;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: ack after ack_delay wait cycles, one-cycle pulse
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (force_ack) begin
            mem_ack = 1'b1;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = mem_resp;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Scoreboard: every completion pulse must match the oldest expectation
   initial begin
      exp_t        e;
      logic [42:0] obs, req;
      forever begin
         @(posedge clk); #1;
         if (instr_ready || data_ready || console_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_unexpected: instr_ready=%0b data_ready=%0b console_valid=%0b with nothing expected",
                        instr_ready, data_ready, console_valid);
            end else begin
               e = exp_q.pop_front();
               obs = {instr_ready, data_ready, console_valid,
                      e.chk ? (e.is_data ? data_rdata : instr_data) : 32'h0,
                      console_valid ? console_data : 8'h0};
               req = {!e.is_data, e.is_data, e.console,
                      e.chk ? e.rdata : 32'h0, e.console ? e.cdata : 8'h0};
               if (obs !== req) begin
                  tests_failed++;
                  $display("FAIL sb_completion: got {ir,dr,cv,rdata,cdata}=%h want %h", obs, req);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (all_out !== '0) begin
         tests_failed++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (all_out !== '0) begin
         tests_failed++; $display("FAIL idle_after_release: got %h want 0", all_out);
      end
   endtask

   task automatic test_instr_read();
      mem_resp = 32'hDEAD_BEEF; ack_delay = 0;
      exp_q.push_back(make_exp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'h0));
      @(negedge clk); instr_enable = 1'b1; instr_address = 32'h0000_0127;
      @(posedge clk); #1;
      tests_run++;
      if (mem_req !== 1'b0) begin
         tests_failed++; $display("FAIL ifetch_req_edge0: got %0b want 0", mem_req);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({mem_req, mem_write, mem_address, mem_byte_enable} !== {1'b1, 1'b0, 30'h49, 4'hF}) begin
         tests_failed++;
         $display("FAIL ifetch_cmd_edge1: got req=%0b wr=%0b addr=%h be=%h want 1 0 49 f",
                  mem_req, mem_write, mem_address, mem_byte_enable);
      end
      @(posedge clk); #1;
      tests_run++;
      if (instr_ready !== 1'b0) begin
         tests_failed++; $display("FAIL ifetch_ready_edge2: got %0b want 0", instr_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({instr_ready, instr_data} !== {1'b1, 32'hDEAD_BEEF}) begin
         tests_failed++;
         $display("FAIL ifetch_ready_edge3: got ready=%0b data=%h want 1 deadbeef", instr_ready, instr_data);
      end
      @(negedge clk); instr_enable = 1'b0;
   endtask

   task automatic test_data_write();
      bit seen;
      mem_resp = 32'h0; ack_delay = 0; seen = 1'b0;
      exp_q.push_back(make_exp(1'b1, 1'b0, 1'b0, 32'h0, 8'h0));
      @(negedge clk);
      data_enable = 1'b1; data_state = WRITE; data_address = 32'h0000_0100;
      data_frame_mask = 4'b1000; data_wdata = 32'h1122_3344;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests_run++;
      if ({mem_req, mem_write, mem_address, mem_byte_enable, mem_wdata} !==
          {1'b1, 1'b1, 30'h40, 4'b0001, 32'h1122_3344}) begin
         tests_failed++;
         $display("FAIL dwrite_cmd: got req=%0b wr=%0b addr=%h be=%b wdata=%h want 1 1 40 0001 11223344",
                  mem_req, mem_write, mem_address, mem_byte_enable, mem_wdata);
      end
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         if (data_ready) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin
         tests_failed++; $display("FAIL dwrite_timeout: data_ready got 0 want 1 within 40 cycles");
      end
      @(negedge clk); data_enable = 1'b0;
   endtask

   task automatic test_streak();
      int pulses;
      pulses = 0;
      mem_resp = 32'hCAFE_0001; ack_delay = 0;
      for (int r = 0; r < 2; r++) begin
         for (int d = 0; d < 4; d++) exp_q.push_back(make_exp(1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 8'h0));
         exp_q.push_back(make_exp(1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 8'h0));
      end
      @(negedge clk);
      instr_enable = 1'b1; instr_address = 32'h0000_0200;
      data_enable = 1'b1; data_state = READ; data_address = 32'h0000_0300; data_frame_mask = 4'hF;
      for (int c = 0; c < 200 && pulses < 10; c++) begin
         @(posedge clk); #1;
         if (instr_ready || data_ready) pulses++;
      end
      @(negedge clk); instr_enable = 1'b0; data_enable = 1'b0;
      tests_run++;
      if (pulses != 10) begin
         tests_failed++; $display("FAIL streak_pulses: got %0d want 10", pulses);
      end
   endtask

   task automatic test_console();
      bit seen;
      seen = 1'b0;
      exp_q.push_back(make_exp(1'b1, 1'b1, 1'b0, 32'h0, 8'h41));
      @(negedge clk);
      data_enable = 1'b1; data_state = WRITE; data_address = 32'h1000_0000;
      data_frame_mask = 4'b1000; data_wdata = 32'h0000_0041;
      @(posedge clk); #1;
      tests_run++;
      if ({mem_req, data_ready, console_valid} !== 3'b000) begin
         tests_failed++;
         $display("FAIL console_edge0: got req=%0b dr=%0b cv=%0b want 000", mem_req, data_ready, console_valid);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({data_ready, console_valid, console_data, mem_req} !== {1'b1, 1'b1, 8'h41, 1'b0}) begin
         tests_failed++;
         $display("FAIL console_edge1: got dr=%0b cv=%0b cd=%h req=%0b want 1 1 41 0",
                  data_ready, console_valid, console_data, mem_req);
      end
      @(negedge clk); data_enable = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if ({console_valid, mem_req} !== 2'b00) begin
         tests_failed++; $display("FAIL console_single: got cv=%0b req=%0b want 0 0", console_valid, mem_req);
      end
      mem_resp = 32'hFFFF_FFFF;
      exp_q.push_back(make_exp(1'b1, 1'b0, 1'b1, 32'h0, 8'h0));
      @(negedge clk); data_enable = 1'b1; data_state = READ; data_address = 32'h1000_0002;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (data_ready) seen = 1'b1;
         tests_run++;
         if (mem_req !== 1'b0) begin
            tests_failed++; $display("FAIL console_read_req: got %0b want 0", mem_req);
         end
      end
      @(negedge clk); data_enable = 1'b0;
   endtask

   task automatic test_slow_ack();
      bit seen;
      int pulses;
      seen = 1'b0; pulses = 0;
      mem_resp = 32'h1357_9BDF; ack_delay = 10;
      exp_q.push_back(make_exp(1'b1, 1'b0, 1'b1, 32'h1357_9BDF, 8'h0));
      @(negedge clk); data_enable = 1'b1; data_state = READ; data_address = 32'h0000_0400;
      @(posedge clk);
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk); data_address = $urandom();
         @(posedge clk); #1;
         if (data_ready) begin
            seen = 1'b1; pulses++;
         end else begin
            tests_run++;
            if (!mem_ack && {mem_req, mem_address} !== {1'b1, 30'h100}) begin
               tests_failed++;
               $display("FAIL slow_hold: got req=%0b addr=%h want 1 100", mem_req, mem_address);
            end else if (mem_ack && mem_req !== 1'b0) begin
               tests_failed++; $display("FAIL slow_drop: got req=%0b want 0 after ack", mem_req);
            end
         end
      end
      @(negedge clk); data_enable = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (data_ready) pulses++;
      end
      tests_run++;
      if (pulses != 1) begin
         tests_failed++; $display("FAIL slow_pulses: got %0d want 1", pulses);
      end
      ack_delay = 0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 1'b0;
      ack_delay = 5;
      @(negedge clk);
      data_enable = 1'b1; data_state = WRITE; data_address = 32'h0000_0500;
      data_frame_mask = 4'hF; data_wdata = 32'hAAAA_5555;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (mem_req !== 1'b1) begin
         tests_failed++; $display("FAIL rstmid_busy: got req=%0b want 1", mem_req);
      end
      @(negedge clk); reset = 1'b0; force_ack = 1'b1;
      #1;
      tests_run++;
      if (all_out !== '0) begin
         tests_failed++; $display("FAIL rstmid_immediate: got %h want 0", all_out);
      end
      repeat (3) begin
         @(posedge clk); #1;
         tests_run++;
         if (all_out !== '0) begin
            tests_failed++; $display("FAIL rstmid_held: got %h want 0", all_out);
         end
      end
      @(negedge clk); force_ack = 1'b0; data_enable = 1'b0; ack_delay = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      mem_resp = 32'hA5A5_5A5A;
      exp_q.push_back(make_exp(1'b0, 1'b0, 1'b1, 32'hA5A5_5A5A, 8'h0));
      @(negedge clk); instr_enable = 1'b1; instr_address = 32'h0000_0600;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (instr_ready) seen = 1'b1;
      end
      tests_run++;
      if ({seen, instr_data} !== {1'b1, 32'hA5A5_5A5A}) begin
         tests_failed++;
         $display("FAIL rstmid_refetch: got seen=%0b data=%h want 1 a5a55a5a", seen, instr_data);
      end
      @(negedge clk); instr_enable = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      instr_enable = 1'b0; instr_address = 32'h0;
      data_enable = 1'b0; data_state = READ; data_address = 32'h0;
      data_frame_mask = 4'h0; data_wdata = 32'h0;
      test_reset();
      test_instr_read();
      test_data_write();
      test_streak();
      test_console();
      test_slow_ack();
      test_reset_mid();
      repeat (5) @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
